// File: rtl/branch_ctrl_if.sv
// ============================================================================
// branch_ctrl_if : fetch/compare/branch signal bundle for branch_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

interface branch_ctrl_if;
  logic        pc_en;
  logic        cmp_issue;
  logic        cmp_valid;
  logic        zf_in;
  logic        cf_in;
  logic        br_valid;
  logic [2:0]  br_op;
  logic [17:0] br_target;
  logic        br_ready;
  logic [17:0] pc;
  logic        taken;
  logic        flush;
  logic        stall;

  modport master (
    output pc_en, cmp_issue, cmp_valid, zf_in, cf_in, br_valid, br_op, br_target,
    input  br_ready, pc, taken, flush, stall
  );

  modport slave (
    input  pc_en, cmp_issue, cmp_valid, zf_in, cf_in, br_valid, br_op, br_target,
    output br_ready, pc, taken, flush, stall
  );
endinterface

`default_nettype wire

// File: rtl/branch_ctrl.sv
// ============================================================================
// branch_ctrl : program counter with conditional branch resolution and flag wait
// Rev 1.0
// ============================================================================
`default_nettype none

module branch_ctrl (
  input  wire logic    clk_i,
  input  wire logic    rst_i,
  branch_ctrl_if.slave bus
);

  localparam logic [2:0] C_OP_JMP = 3'b000;
  localparam logic [2:0] C_OP_JE  = 3'b001;
  localparam logic [2:0] C_OP_JNE = 3'b010;
  localparam logic [2:0] C_OP_JB  = 3'b011;
  localparam logic [2:0] C_OP_JA  = 3'b100;
  localparam logic [2:0] C_OP_JAE = 3'b101;
  localparam logic [2:0] C_OP_JBE = 3'b110;

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [17:0] pc_q, pc_d;
  logic        taken_q, taken_d;
  logic        zf_q, zf_d;
  logic        cf_q, cf_d;
  logic        fv_q, fv_d;

  logic        w_resolve;
  logic        w_take;
  logic        w_ready;
  logic        w_stall;

  function automatic logic cond_met(input logic [2:0] op, input logic zf, input logic cf);
    case (op)
      C_OP_JMP: cond_met = 1'b1;
      C_OP_JE:  cond_met = zf;
      C_OP_JNE: cond_met = ~zf;
      C_OP_JB:  cond_met = cf;
      C_OP_JA:  cond_met = ~zf & ~cf;
      C_OP_JAE: cond_met = ~cf;
      C_OP_JBE: cond_met = zf | cf;
      default:  cond_met = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    w_resolve = 1'b0;
    w_take    = 1'b0;
    w_stall   = 1'b0;
    case (state_q)
      S_RUN: begin
        if (bus.br_valid) begin
          if ((bus.br_op == C_OP_JMP) || (fv_q && !bus.cmp_issue)) begin
            w_resolve = 1'b1;
            w_take    = cond_met(bus.br_op, zf_q, cf_q);
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      default: begin
        w_stall = 1'b1;
        if (!bus.br_valid) begin
          state_d = S_RUN;
        end else if (bus.cmp_valid) begin
          // Flags arriving this cycle are forwarded straight into the decision
          w_resolve = 1'b1;
          w_take    = cond_met(bus.br_op, bus.zf_in, bus.cf_in);
          state_d   = S_RUN;
        end
      end
    endcase
    w_ready = w_resolve & ~rst_i;
  end

  always_comb begin
    pc_d    = pc_q;
    taken_d = 1'b0;
    if (w_resolve) begin
      if (w_take) begin
        pc_d    = bus.br_target;
        taken_d = 1'b1;
      end else if (bus.pc_en) begin
        pc_d = pc_q + 18'd1;
      end
    end else if (bus.pc_en && !w_stall) begin
      pc_d = pc_q + 18'd1;
    end
  end

  // Issue of a new compare invalidates flags even when a result lands the same cycle
  always_comb begin
    zf_d = zf_q;
    cf_d = cf_q;
    fv_d = fv_q;
    if (bus.cmp_valid) begin
      zf_d = bus.zf_in;
      cf_d = bus.cf_in;
      fv_d = 1'b1;
    end
    if (bus.cmp_issue) begin
      fv_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_RUN;
      pc_q    <= 18'd0;
      taken_q <= 1'b0;
      zf_q    <= 1'b0;
      cf_q    <= 1'b0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      taken_q <= taken_d;
      zf_q    <= zf_d;
      cf_q    <= cf_d;
      fv_q    <= fv_d;
    end
  end

  assign bus.br_ready = w_ready;
  assign bus.stall    = w_stall & ~rst_i;
  assign bus.pc       = pc_q;
  assign bus.taken    = taken_q;
  assign bus.flush    = taken_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_ctrl.sv
// ============================================================================
// tb_branch_ctrl : directed self-checking bench for branch_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_branch_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  branch_ctrl_if bif ();

  branch_ctrl dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_regs(input string tag, input logic [17:0] pc, input logic tk, input logic st);
    chk({tag, "_pc"},    32'(bif.pc),    32'(pc));
    chk({tag, "_taken"}, 32'(bif.taken), 32'(tk));
    chk({tag, "_flush"}, 32'(bif.flush), 32'(tk));
    chk({tag, "_stall"}, 32'(bif.stall), 32'(st));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    rst           = 1'b1;
    bif.pc_en     = 1'b0;
    bif.cmp_issue = 1'b0;
    bif.cmp_valid = 1'b0;
    bif.zf_in     = 1'b0;
    bif.cf_in     = 1'b0;
    bif.br_valid  = 1'b0;
    bif.br_op     = 3'b000;
    bif.br_target = 18'd0;
    tick();
    tick();
    chk_regs("reset", 18'd0, 1'b0, 1'b0);

    // Sequential advance
    rst       = 1'b0;
    bif.pc_en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("seq_pc", 32'(bif.pc), 32'(i));
    end

    // Preset near the top via JMP, then wrap
    bif.pc_en     = 1'b0;
    bif.br_valid  = 1'b1;
    bif.br_op     = 3'b000;
    bif.br_target = 18'h3FFFE;
    settle();
    chk("jmp_ready", 32'(bif.br_ready), 32'd1);
    tick();
    bif.br_valid = 1'b0;
    bif.pc_en    = 1'b1;
    chk_regs("jmp_preset", 18'h3FFFE, 1'b1, 1'b0);
    tick();
    chk_regs("wrap1", 18'h3FFFF, 1'b0, 1'b0);
    tick();
    chk_regs("wrap2", 18'h00000, 1'b0, 1'b0);
    bif.pc_en = 1'b0;

    // Registered flags, JE taken
    bif.cmp_valid = 1'b1;
    bif.zf_in     = 1'b1;
    bif.cf_in     = 1'b0;
    tick();
    bif.cmp_valid = 1'b0;
    bif.br_valid  = 1'b1;
    bif.br_op     = 3'b001;
    bif.br_target = 18'h00100;
    settle();
    chk("je_ready", 32'(bif.br_ready), 32'd1);
    tick();
    bif.br_valid = 1'b0;
    chk_regs("je_taken", 18'h00100, 1'b1, 1'b0);
    tick();
    chk_regs("je_after", 18'h00100, 1'b0, 1'b0);

    // Pending flags: wait then forwarded resolve
    bif.cmp_issue = 1'b1;
    tick();
    bif.cmp_issue = 1'b0;
    bif.br_valid  = 1'b1;
    bif.br_op     = 3'b011;
    bif.br_target = 18'h2AAAA;
    settle();
    chk("jb_notready", 32'(bif.br_ready), 32'd0);
    tick();
    chk("jb_wait_stall", 32'(bif.stall), 32'd1);
    chk("jb_wait_ready", 32'(bif.br_ready), 32'd0);
    tick();
    tick();
    chk_regs("jb_wait_hold", 18'h00100, 1'b0, 1'b1);
    bif.cmp_valid = 1'b1;
    bif.zf_in     = 1'b0;
    bif.cf_in     = 1'b1;
    settle();
    chk("jb_fwd_ready", 32'(bif.br_ready), 32'd1);
    tick();
    bif.cmp_valid = 1'b0;
    bif.br_valid  = 1'b0;
    settle();
    chk_regs("jb_taken", 18'h2AAAA, 1'b1, 1'b0);

    // Flags zf=0 cf=0
    bif.cmp_valid = 1'b1;
    bif.zf_in     = 1'b0;
    bif.cf_in     = 1'b0;
    tick();
    bif.cmp_valid = 1'b0;
    bif.br_valid  = 1'b1;
    bif.br_op     = 3'b100;
    bif.br_target = 18'h00200;
    settle();
    chk("ja_ready", 32'(bif.br_ready), 32'd1);
    tick();
    chk_regs("ja_taken", 18'h00200, 1'b1, 1'b0);
    bif.br_op     = 3'b110;
    bif.br_target = 18'h00300;
    bif.pc_en     = 1'b1;
    settle();
    chk("jbe_ready", 32'(bif.br_ready), 32'd1);
    tick();
    chk_regs("jbe_nt", 18'h00201, 1'b0, 1'b0);
    bif.br_op     = 3'b111;
    bif.br_target = 18'h00400;
    settle();
    chk("rsv_ready", 32'(bif.br_ready), 32'd1);
    tick();
    chk_regs("rsv_nt", 18'h00202, 1'b0, 1'b0);

    // JMP with flags invalidated
    bif.br_valid  = 1'b0;
    bif.pc_en     = 1'b0;
    bif.cmp_issue = 1'b1;
    tick();
    bif.cmp_issue = 1'b0;
    bif.br_valid  = 1'b1;
    bif.br_op     = 3'b000;
    bif.br_target = 18'h01234;
    settle();
    chk("jmp_nf_ready", 32'(bif.br_ready), 32'd1);
    tick();
    bif.br_valid = 1'b0;
    chk_regs("jmp_nf", 18'h01234, 1'b1, 1'b0);

    // Withdrawn request leaves WAIT without resolving
    bif.br_valid = 1'b1;
    bif.br_op    = 3'b010;
    tick();
    chk("wd_stall", 32'(bif.stall), 32'd1);
    bif.br_valid = 1'b0;
    settle();
    chk("wd_ready", 32'(bif.br_ready), 32'd0);
    tick();
    chk_regs("wd_run", 18'h01234, 1'b0, 1'b0);

    // Issue wins over same-cycle valid, JE must wait
    bif.cmp_issue = 1'b1;
    bif.cmp_valid = 1'b1;
    bif.zf_in     = 1'b1;
    tick();
    bif.cmp_issue = 1'b0;
    bif.cmp_valid = 1'b0;
    bif.br_valid  = 1'b1;
    bif.br_op     = 3'b001;
    bif.br_target = 18'h05000;
    settle();
    chk("iw_ready", 32'(bif.br_ready), 32'd0);
    tick();
    chk_regs("iw_wait", 18'h01234, 1'b0, 1'b1);

    // Reset in WAIT overrides a same-cycle taken resolve
    rst           = 1'b1;
    bif.cmp_valid = 1'b1;
    bif.zf_in     = 1'b1;
    settle();
    chk("rw_ready", 32'(bif.br_ready), 32'd0);
    chk("rw_stall", 32'(bif.stall), 32'd0);
    tick();
    rst           = 1'b0;
    bif.cmp_valid = 1'b0;
    bif.br_valid  = 1'b0;
    settle();
    chk_regs("rw_post", 18'd0, 1'b0, 1'b0);
    tick();
    chk_regs("rw_post2", 18'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 The module SHALL have no parameters: all widths are fixed; PC width 18, op width 3.
REQ-002 Clock  input  1  single system clock; all state updates on the rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset, sampled on the rising edge of Clock.
REQ-004 pc_en  input  1  sequential-advance enable from the fetch stage.
REQ-005 cmp_issue  input  1  a compare has been issued; its flags are now in flight.
REQ-006 cmp_valid  input  1  compare result valid this cycle; zf_in/cf_in are meaningful.
REQ-007 zf_in, cf_in  input  1 each  zero/carry flags from the comparator (equal / a<b).
REQ-008 br_valid  input  1  branch request present; br_op/br_target held stable until accepted.
REQ-009 br_op  input  3  condition: 000 JMP, 001 JE, 010 JNE, 011 JB, 100 JA, 101 JAE, 110 JBE, 111 reserved.
REQ-010 br_target  input  18  absolute branch destination.
REQ-011 br_ready  output  1  branch accepted and resolved this cycle (combinational).
REQ-012 pc  output  18  registered program counter.
REQ-013 taken  output  1  registered one-cycle pulse: last accepted branch was taken.
REQ-014 flush  output  1  registered one-cycle pulse: discard fetched instruction (equals taken).
REQ-015 stall  output  1  high while in WAIT (branch held pending flags).

Function
REQ-016 Flag register zf_q, cf_q, flags_valid SHALL load zf_in/cf_in and set flags_valid on cmp_valid.
REQ-017 cmp_issue SHALL clear flags_valid next edge; cmp_issue and cmp_valid in the same cycle -> flags loaded, flags_valid cleared (issue wins).
REQ-018 Conditions SHALL be: JMP 1; JE zf; JNE ~zf; JB cf; JA ~zf&~cf; JAE ~cf; JBE zf|cf; reserved 0 (accepted, not taken).
REQ-019 FSM SHALL have two states: RUN and WAIT.
REQ-020 RUN: usable = (br_op==JMP) | (flags_valid & ~cmp_issue); br_valid & usable -> br_ready=1, resolve with zf_q/cf_q, stay RUN.
REQ-021 RUN: br_valid & ~usable -> br_ready=0, next state WAIT.
REQ-022 WAIT: stall=1; br_ready = cmp_valid; on cmp_valid resolve with zf_in/cf_in forwarded (not zf_q/cf_q), next state RUN.
REQ-023 WAIT with br_valid deasserted SHALL return to RUN without resolving (request withdrawn).
REQ-024 Resolve taken -> pc <= br_target next edge, taken=flush=1 for exactly that following cycle, regardless of pc_en.
REQ-025 Resolve not-taken -> pc <= pc+1 next edge if pc_en, else pc held; taken=flush=0.
REQ-026 No resolve: pc <= pc+1 when pc_en & ~stall, else hold.
REQ-027 PC arithmetic SHALL be modulo 2^18: 0x3FFFF+1 -> 0x00000.
REQ-028 Latency: resolve-to-pc-update 1 cycle; flags-to-usable 1 cycle via register, 0 cycles via WAIT forwarding.
REQ-029 Back-to-back branches on consecutive cycles SHALL each resolve independently; taken/flush reflect only the most recent resolve.

Reset
REQ-030 Reset SHALL force: pc=0, state RUN, flags_valid=0, zf_q=cf_q=0, taken=flush=0.
REQ-031 Reset asserted in WAIT SHALL drop the pending branch; br_ready=0 and stall=0 during the reset cycle.
REQ-032 Reset SHALL override all same-cycle inputs including cmp_valid and a taken resolve.

Verification
REQ-033 Reset, pc_en=1 for 5 cycles -> pc 0,1,2,3,4,5; pc preset 0x3FFFE, 2 cycles -> 0x3FFFF, 0x00000.
REQ-034 cmp_valid zf=1 cf=0, next cycle br_valid JE target 0x00100 -> br_ready=1 same cycle, pc=0x00100 next, taken=flush=1 one cycle.
REQ-035 cmp_issue, then br_valid JB -> stall=1, br_ready=0; 3 cycles later cmp_valid cf=1 -> br_ready=1, pc=target, stall=0 next cycle.
REQ-036 Flags zf=0 cf=0: JA taken, JBE not taken (pc+1), op 111 accepted not taken, JMP taken with flags_valid=0.
REQ-037 cmp_issue and cmp_valid same cycle, then JE -> WAIT entered (flags_valid=0).
REQ-038 In WAIT assert Reset -> pc=0, state RUN, stall=0, no taken pulse.
